// File: rtl/pwm_gen.sv
// Percent-resolution PWM: en latches duty (clamped to 100) and restarts a 100-segment period.
// Latency 1 clk from the en edge to the first high cycle; no backpressure, free-running until clr.
module pwm_gen #(
  parameter int CLKS_PER_SEG = 10,
  parameter int WIDTH        = 7
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] duty_cycle,
  output logic             out
);

  localparam int CW = (CLKS_PER_SEG > 1) ? $clog2(CLKS_PER_SEG) : 1;
  localparam logic [CW-1:0]    CC_LAST  = CW'(CLKS_PER_SEG - 1);
  localparam logic [WIDTH-1:0] SEG_LAST = WIDTH'(99);
  localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(100);

  logic             running;
  logic [WIDTH-1:0] duty_reg;
  logic [CW-1:0]    clock_count;
  logic [WIDTH-1:0] segments;

  logic             running_nxt;
  logic [WIDTH-1:0] duty_nxt;
  logic [CW-1:0]    cc_nxt;
  logic [WIDTH-1:0] seg_nxt;
  logic [WIDTH-1:0] duty_clamped;

  assign duty_clamped = (duty_cycle > DUTY_MAX) ? DUTY_MAX : duty_cycle;

  always_comb begin
    running_nxt = running;
    duty_nxt    = duty_reg;
    cc_nxt      = clock_count;
    seg_nxt     = segments;
    if (en) begin
      running_nxt = 1'b1;
      duty_nxt    = duty_clamped;
      cc_nxt      = '0;
      seg_nxt     = '0;
    end else if (running) begin
      if (clock_count == CC_LAST) begin
        cc_nxt  = '0;
        seg_nxt = (segments == SEG_LAST) ? '0 : segments + WIDTH'(1);
      end else begin
        cc_nxt = clock_count + CW'(1);
      end
    end
  end

  // out is registered from next-state so it lines up with the counters it describes
  always_ff @(posedge clk) begin
    if (!clr) begin
      running     <= 1'b0;
      duty_reg    <= '0;
      clock_count <= '0;
      segments    <= '0;
      out         <= 1'b0;
    end else begin
      running     <= running_nxt;
      duty_reg    <= duty_nxt;
      clock_count <= cc_nxt;
      segments    <= seg_nxt;
      out         <= running_nxt && (seg_nxt < duty_nxt);
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Randomized scoreboard bench for pwm_gen against a time-since-start reference model.
module tb_pwm_gen;

  localparam int C      = 10;
  localparam int W      = 7;
  localparam int PERIOD = 100 * C;

  logic         clk;
  logic         clr;
  logic         en;
  logic [W-1:0] duty_cycle;
  logic         out;

  pwm_gen #(.CLKS_PER_SEG(C), .WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .duty_cycle (duty_cycle),
    .out        (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         o;
    logic [3:0]   cc;
    logic [W-1:0] seg;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // reference model: elapsed clocks since the last start
  bit m_running = 1'b0;
  int m_t       = 0;
  int m_duty    = 0;

  task automatic step(input logic c, input logic e, input logic [W-1:0] d);
    exp_t x;
    @(negedge clk);
    clr        = c;
    en         = e;
    duty_cycle = d;
    if (!c) begin
      m_running = 1'b0;
      m_t       = 0;
      m_duty    = 0;
    end else if (e) begin
      m_running = 1'b1;
      m_t       = 0;
      m_duty    = (int'(d) > 100) ? 100 : int'(d);
    end else if (m_running) begin
      m_t = m_t + 1;
    end
    x.o   = m_running && ((m_t % PERIOD) < m_duty * C);
    x.cc  = m_running ? 4'(m_t % C) : 4'd0;
    x.seg = m_running ? W'((m_t / C) % 100) : W'(0);
    sb.push_back(x);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom_range(0, 127)));
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      compared++;
      if (out !== mon_e.o) begin
        mismatched++;
        $display("FAIL out t=%0t actual=%b required=%b", $time, out, mon_e.o);
      end
      compared++;
      if (dut.clock_count !== mon_e.cc) begin
        mismatched++;
        $display("FAIL clock_count t=%0t actual=%0d required=%0d", $time, dut.clock_count, mon_e.cc);
      end
      compared++;
      if (dut.segments !== mon_e.seg) begin
        mismatched++;
        $display("FAIL segments t=%0t actual=%0d required=%0d", $time, dut.segments, mon_e.seg);
      end
    end
  end

  initial begin
    clr        = 1'b0;
    en         = 1'b0;
    duty_cycle = '0;

    // reset, then 90% for 4+ periods
    step(1'b0, 1'b0, W'(90));
    step(1'b1, 1'b1, W'(90));
    run(4 * PERIOD + 50);

    // idle after reset: duty changes and en=0 must not move anything
    step(1'b0, 1'b0, W'(0));
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, (i % 2 == 0) ? W'(50) : W'($urandom_range(0, 127)));

    // restart at segment 40 of a 90% run
    step(1'b1, 1'b1, W'(90));
    run(400);
    step(1'b1, 1'b1, W'(30));
    run(PERIOD + 100);

    // duty boundaries
    step(1'b1, 1'b1, W'(0));
    run(2 * PERIOD);
    step(1'b1, 1'b1, W'(100));
    run(PERIOD + 20);
    step(1'b1, 1'b1, W'(120));
    run(PERIOD + 20);

    // clr wins over en mid-run, then stays idle until a real start
    step(1'b1, 1'b1, W'(60));
    run(333);
    step(1'b0, 1'b1, W'(60));
    run(150);
    step(1'b1, 1'b1, W'(45));
    run(PERIOD);

    // randomized starts, stray en re-latches and occasional clr
    for (int k = 0; k < 6; k++) begin
      int len;
      step(1'b1, 1'b1, W'($urandom_range(0, 127)));
      len = $urandom_range(200, 2500);
      for (int i = 0; i < len; i++) begin
        int r;
        r = $urandom_range(0, 999);
        if (r < 3)       step(1'b1, 1'b1, W'($urandom_range(0, 127)));
        else if (r == 3) step(1'b0, $urandom_range(0, 1) == 1, W'($urandom_range(0, 127)));
        else             step(1'b1, 1'b0, W'($urandom_range(0, 127)));
      end
    end

    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
Percent-resolution PWM generator for the motor-control path. A one-cycle enable strobe latches a duty cycle in percent and starts a free-running PWM period of 100 segments. Each segment is CLKS_PER_SEG clocks long. The generator then runs autonomously until cleared, driving a single output that is high for duty percent of each period.

Parameters:
CLKS_PER_SEG, 10, clock cycles per 1% segment; must be >= 1; period = 100*CLKS_PER_SEG clocks.
WIDTH, 7, bit width of duty_cycle and of the internal segment counter; must be >= 7 so that 100 is representable.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
clr  input  1  synchronous active-low reset; clr=0 sampled at a rising edge clears all state.
en  input  1  start/load strobe, active-high; sampled each rising edge.
duty_cycle  input  WIDTH  requested duty in percent (0..100); values >100 are treated as 100.
out  output  1  PWM output, driven from registers only.

Behaviour:
- Internal state:
  - running flag.
  - duty_reg [WIDTH].
  - clock_count: counts 0..CLKS_PER_SEG-1; width max(1, clog2(CLKS_PER_SEG)).
  - segments [WIDTH]: counts 0..99.
- Reset (clr=0 at edge):
  - running=0, duty_reg=0, clock_count=0, segments=0.
  - out=0 from the following cycle.
  - clr has priority over en.
  - Reset mid-period aborts immediately; no output activity until the next en.
- Idle (running=0):
  - Counters hold at 0; out=0.
  - duty_cycle changes are ignored.
- Start (clr=1, en=1 at edge):
  - duty_reg <= min(duty_cycle, 100).
  - running <= 1.
  - clock_count <= 0; segments <= 0.
  - en=1 while already running has the same effect: re-latches duty and restarts the period at segment 0.
- Running, en=0:
  - clock_count increments each edge.
  - When clock_count = CLKS_PER_SEG-1, it wraps to 0 and segments increments.
  - When segments = 99 and clock_count wraps, segments wraps to 0. The generator continues indefinitely.
  - en need not stay high; a single-cycle pulse suffices.
- Output:
  - out = running AND (segments < duty_reg), computed from registered state only.
  - First high cycle is the cycle after the start edge (latency 1 clock from the en edge).
  - duty 0: out never high. duty >= 100: out constantly high while running.
  - Per period: out high for duty*CLKS_PER_SEG consecutive clocks, then low for (100-duty)*CLKS_PER_SEG clocks.
- duty_cycle is sampled only on the en edge. Later input changes take effect only on the next en.
- No combinational path from any input to out.

Test Plan:
- Reset then start, 90% duty, CLKS_PER_SEG=10:
  - Stimulus: clr=0 one edge; clr=1, en=1 one edge with duty_cycle=90; then en=0.
  - Required: out high 900 clocks, low 100 clocks, period 1000, repeating for at least 4 periods.
- Output before start:
  - Stimulus: reset, then hold en=0 for 200 clocks with duty_cycle=50.
  - Required: out=0 and counters stay at 0.
- Duty boundaries:
  - duty_cycle=0 → out never high over 2 periods.
  - duty_cycle=100 → out constantly 1.
  - duty_cycle=120 → same as 100.
- Counter wrap checks:
  - clock_count runs 0..9 then wraps; segments increments exactly on each wrap.
  - segments 99 → 0 at the period boundary with no idle cycle.
- Restart mid-period:
  - Stimulus: at segment 40 of a 90% run, pulse en with duty_cycle=30.
  - Required: counters restart at 0; out high 300 clocks, then low 700 clocks.
- Reset priority:
  - Stimulus: clr=0 and en=1 on the same edge mid-run.
  - Required: state cleared, out=0, generator stays idle until a later en with clr=1.
